// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down-counter/timer: state encoding and default width.
package down_counter_timer_pkg;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes, pause/resume,
// and a registered one-cycle terminal-count pulse.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             tc
);

  logic             state;
  logic [WIDTH-1:0] reload_reg;

  assign busy = (state == STATE_RUN);

  // Priority per cycle: load > stop > start > count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= STATE_IDLE;
      dout       <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        dout       <= load_val;
        reload_reg <= load_val;
        state      <= STATE_IDLE;
      end else if (stop) begin
        state <= STATE_IDLE;
      end else if (state == STATE_IDLE) begin
        if (start && (dout != '0))
          state <= STATE_RUN;
      end else if (dout > WIDTH'(1)) begin
        dout <= dout - WIDTH'(1);
      end else if (dout == WIDTH'(1)) begin
        tc <= 1'b1;
        // auto_reload is only looked at here, so mid-count changes apply at expiry.
        if (auto_reload && (reload_reg != '0)) begin
          dout <= reload_reg;
        end else begin
          dout  <= '0;
          state <= STATE_IDLE;
        end
      end else begin
        state <= STATE_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Table-driven bench for down_counter_timer (WIDTH=8 and WIDTH=2 instances).
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load, start, stop, auto_reload;
  logic [7:0] load_val;
  logic [7:0] dout;
  logic       busy, tc;

  logic       n_load, n_start, n_stop, n_auto_reload;
  logic [1:0] n_load_val;
  logic [1:0] n_dout;
  logic       n_busy, n_tc;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .dout(dout), .busy(busy), .tc(tc)
  );

  down_counter_timer #(.WIDTH(2)) dut_w2 (
    .clk(clk), .reset_n(reset_n), .load(n_load), .load_val(n_load_val),
    .start(n_start), .stop(n_stop), .auto_reload(n_auto_reload),
    .dout(n_dout), .busy(n_busy), .tc(n_tc)
  );

  typedef struct packed {
    logic       narrow;
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       sp;
    logic       ar;
    logic [7:0] ed;
    logic       eb;
    logic       et;
  } vec_t;

  typedef struct packed {
    logic       narrow;
    logic [7:0] ed;
    logic       eb;
    logic       et;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t V(input logic n, input logic ld, input logic [7:0] lv,
                             input logic st, input logic sp, input logic ar,
                             input logic [7:0] ed, input logic eb, input logic et);
    vec_t v;
    v.narrow = n; v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.ar = ar;
    v.ed = ed; v.eb = eb; v.et = et;
    return v;
  endfunction

  function automatic vec_t I(input logic n, input logic ar, input logic [7:0] ed,
                             input logic eb, input logic et);
    return V(n, 1'b0, 8'd0, 1'b0, 1'b0, ar, ed, eb, et);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, want %0d", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    load = 0; start = 0; stop = 0; auto_reload = 0; load_val = 0;
    n_load = 0; n_start = 0; n_stop = 0; n_auto_reload = 0; n_load_val = 0;
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    idle_inputs();
    if (v.narrow) begin
      n_load = v.ld; n_load_val = v.lv[1:0]; n_start = v.st; n_stop = v.sp;
      n_auto_reload = v.ar;
    end else begin
      load = v.ld; load_val = v.lv; start = v.st; stop = v.sp; auto_reload = v.ar;
    end
    e.narrow = v.narrow; e.ed = v.ed; e.eb = v.eb; e.et = v.et;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.narrow) begin
      check("w2_dout", idx, int'({6'd0, n_dout}), int'(e.ed));
      check("w2_busy", idx, int'(n_busy), int'(e.eb));
      check("w2_tc",   idx, int'(n_tc),   int'(e.et));
    end else begin
      check("dout", idx, int'(dout), int'(e.ed));
      check("busy", idx, int'(busy), int'(e.eb));
      check("tc",   idx, int'(tc),   int'(e.et));
    end
  endtask

  task automatic check_reset_now(input int idx);
    check("rst_dout", idx, int'(dout), 0);
    check("rst_busy", idx, int'(busy), 0);
    check("rst_tc",   idx, int'(tc),   0);
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_now(0);
    check("rst_w2_dout", 0, int'(n_dout), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // One-shot: load 4 -> 4,3,2,1,0 with tc on the 0 cycle
    vecs.push_back(V(0, 1, 8'd4, 0, 0, 0, 8'd4, 0, 0));
    vecs.push_back(V(0, 0, 8'd0, 1, 0, 0, 8'd4, 1, 0));
    vecs.push_back(I(0, 0, 8'd3, 1, 0));
    vecs.push_back(I(0, 0, 8'd2, 1, 0));
    vecs.push_back(I(0, 0, 8'd1, 1, 0));
    vecs.push_back(I(0, 0, 8'd0, 0, 1));
    vecs.push_back(I(0, 0, 8'd0, 0, 0));
    vecs.push_back(I(0, 0, 8'd0, 0, 0));
    // Auto-reload 3, then drop auto_reload mid-count
    vecs.push_back(V(0, 1, 8'd3, 0, 0, 1, 8'd3, 0, 0));
    vecs.push_back(V(0, 0, 8'd0, 1, 0, 1, 8'd3, 1, 0));
    vecs.push_back(I(0, 1, 8'd2, 1, 0));
    vecs.push_back(I(0, 1, 8'd1, 1, 0));
    vecs.push_back(I(0, 1, 8'd3, 1, 1));
    vecs.push_back(I(0, 1, 8'd2, 1, 0));
    vecs.push_back(I(0, 1, 8'd1, 1, 0));
    vecs.push_back(I(0, 1, 8'd3, 1, 1));
    vecs.push_back(I(0, 1, 8'd2, 1, 0));
    vecs.push_back(I(0, 0, 8'd1, 1, 0));
    vecs.push_back(I(0, 0, 8'd0, 0, 1));
    vecs.push_back(I(0, 0, 8'd0, 0, 0));
    // Pause at 7 for 5 cycles, resume, tc 7 cycles later
    vecs.push_back(V(0, 1, 8'd10, 0, 0, 0, 8'd10, 0, 0));
    vecs.push_back(V(0, 0, 8'd0, 1, 0, 0, 8'd10, 1, 0));
    vecs.push_back(I(0, 0, 8'd9, 1, 0));
    vecs.push_back(I(0, 0, 8'd8, 1, 0));
    vecs.push_back(I(0, 0, 8'd7, 1, 0));
    vecs.push_back(V(0, 0, 8'd0, 0, 1, 0, 8'd7, 0, 0));
    for (int k = 0; k < 4; k++) vecs.push_back(I(0, 0, 8'd7, 0, 0));
    vecs.push_back(V(0, 0, 8'd0, 1, 0, 0, 8'd7, 1, 0));
    for (int k = 6; k >= 1; k--) vecs.push_back(I(0, 0, 8'(k), 1, 0));
    vecs.push_back(I(0, 0, 8'd0, 0, 1));
    // Priority and corners
    vecs.push_back(V(0, 1, 8'd6, 1, 0, 0, 8'd6, 0, 0));
    vecs.push_back(I(0, 0, 8'd6, 0, 0));
    vecs.push_back(V(0, 1, 8'd0, 0, 0, 0, 8'd0, 0, 0));
    vecs.push_back(V(0, 0, 8'd0, 1, 0, 0, 8'd0, 0, 0));
    vecs.push_back(I(0, 0, 8'd0, 0, 0));
    vecs.push_back(V(0, 1, 8'd5, 0, 0, 0, 8'd5, 0, 0));
    vecs.push_back(V(0, 0, 8'd0, 1, 0, 0, 8'd5, 1, 0));
    vecs.push_back(I(0, 0, 8'd4, 1, 0));
    vecs.push_back(V(0, 0, 8'd0, 1, 1, 0, 8'd4, 0, 0));
    vecs.push_back(I(0, 0, 8'd4, 0, 0));
    vecs.push_back(V(0, 0, 8'd0, 1, 0, 0, 8'd4, 1, 0));
    vecs.push_back(I(0, 0, 8'd3, 1, 0));
    vecs.push_back(V(0, 1, 8'd9, 0, 0, 0, 8'd9, 0, 0));
    vecs.push_back(I(0, 0, 8'd9, 0, 0));
    vecs.push_back(V(0, 0, 8'd0, 0, 1, 0, 8'd9, 0, 0));
    // reload_reg == 1 in auto mode: tc every cycle
    vecs.push_back(V(0, 1, 8'd1, 0, 0, 1, 8'd1, 0, 0));
    vecs.push_back(V(0, 0, 8'd0, 1, 0, 1, 8'd1, 1, 0));
    vecs.push_back(I(0, 1, 8'd1, 1, 1));
    vecs.push_back(I(0, 1, 8'd1, 1, 1));
    vecs.push_back(V(0, 0, 8'd0, 0, 1, 1, 8'd1, 0, 0));
    // Full-range load
    vecs.push_back(V(0, 1, 8'd255, 0, 0, 0, 8'd255, 0, 0));
    vecs.push_back(V(0, 0, 8'd0, 1, 0, 0, 8'd255, 1, 0));
    vecs.push_back(I(0, 0, 8'd254, 1, 0));
    vecs.push_back(I(0, 0, 8'd253, 1, 0));
    // WIDTH=2: auto-reload 3, then one-shot to 0 with no underflow
    vecs.push_back(V(1, 1, 8'd3, 0, 0, 1, 8'd3, 0, 0));
    vecs.push_back(V(1, 0, 8'd0, 1, 0, 1, 8'd3, 1, 0));
    vecs.push_back(I(1, 1, 8'd2, 1, 0));
    vecs.push_back(I(1, 1, 8'd1, 1, 0));
    vecs.push_back(I(1, 1, 8'd3, 1, 1));
    vecs.push_back(I(1, 1, 8'd2, 1, 0));
    vecs.push_back(I(1, 1, 8'd1, 1, 0));
    vecs.push_back(I(1, 1, 8'd3, 1, 1));
    vecs.push_back(I(1, 0, 8'd2, 1, 0));
    vecs.push_back(I(1, 0, 8'd1, 1, 0));
    vecs.push_back(I(1, 0, 8'd0, 0, 1));
    vecs.push_back(I(1, 0, 8'd0, 0, 0));
    vecs.push_back(I(1, 0, 8'd0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i + 1);

    // Asynchronous reset mid-run: load 5, start, two counts, then reset between edges
    step(V(0, 1, 8'd5, 0, 0, 0, 8'd5, 0, 0), 200);
    step(V(0, 0, 8'd0, 1, 0, 0, 8'd5, 1, 0), 201);
    step(I(0, 0, 8'd4, 1, 0), 202);
    step(I(0, 0, 8'd3, 1, 0), 203);
    #2 reset_n = 1'b0;
    #1 check_reset_now(204);
    @(negedge clk);
    reset_n = 1'b1;
    // reload_reg was cleared: start on the zero count is ignored
    step(V(0, 0, 8'd0, 1, 0, 1, 8'd0, 0, 0), 205);

    // Reset landing in a tc cycle clears the pulse immediately
    step(V(0, 1, 8'd2, 0, 0, 1, 8'd2, 0, 0), 210);
    step(V(0, 0, 8'd0, 1, 0, 1, 8'd2, 1, 0), 211);
    step(I(0, 1, 8'd1, 1, 0), 212);
    step(I(0, 1, 8'd2, 1, 1), 213);
    #2 reset_n = 1'b0;
    #1 check_reset_now(214);
    @(negedge clk);
    reset_n = 1'b1;
    step(I(0, 0, 8'd0, 0, 0), 215);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable, parameterised binary down-counter and programmable timer. It is the count-down complement to the team's free-running up-counters.
- Software or upstream logic loads a value, starts the count, and receives a one-cycle terminal-count pulse on expiry.
- Supports one-shot and auto-reload (periodic tick) modes, with pause and resume.

Parameters:
- WIDTH, 8, counter and load-value width in bits (2..32).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous active-low reset.
- load  input  1  single-cycle strobe: capture load_val into counter and reload register.
- load_val  input  WIDTH  value to load.
- start  input  1  single-cycle strobe: begin or resume counting.
- stop  input  1  single-cycle strobe: pause counting and hold the count.
- auto_reload  input  1  level, 1 = periodic mode, 0 = one-shot; sampled at each expiry.
- dout  output  WIDTH  current count, registered.
- busy  output  1  high while in RUN, registered.
- tc  output  1  terminal-count pulse, one cycle, registered.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is reset_n.
- Reset (reset_n=0, asynchronous):
  - dout=0, reload_reg=0, state=IDLE, busy=0, tc=0.
  - Deassertion is synchronous to clk at the integrating level.
- State machine has two states, IDLE and RUN. busy=1 exactly when state=RUN.
- Priority per cycle: load > stop > start > count.
- load, in any state:
  - Next cycle: dout=load_val, reload_reg=load_val, state=IDLE, tc=0.
  - start or stop in the same cycle is ignored.
- stop:
  - In RUN: state goes to IDLE and dout holds its value (pause).
  - In IDLE: no effect.
  - A simultaneous start is ignored.
- start:
  - In IDLE with dout!=0: state goes to RUN. The first decrement occurs on the edge after the one that enters RUN.
  - In IDLE with dout==0: ignored, stays IDLE, no tc.
  - In RUN: no effect.
- RUN, dout>1: dout decrements by 1 per cycle; tc=0.
- RUN, dout==1 (expiry edge), tc=1 for exactly one cycle in both modes:
  - auto_reload=0: dout goes to 0, state goes to IDLE.
  - auto_reload=1 and reload_reg>=1: dout goes to reload_reg, stays RUN. Tick period = reload_reg cycles.
- Latency, one-shot: the tc cycle is exactly N cycles after the first RUN cycle for load value N. dout==0 is first visible in the tc cycle.
- Special values:
  - reload_reg==1 in auto mode: tc every cycle, dout stays 1.
  - Resume after stop: counting continues from the held dout, with no reload.
- Arithmetic:
  - Unsigned, WIDTH bits. Decrement never occurs from 0, so no underflow wrap.
  - load_val of all-ones is legal and gives a full-range count.
- Changing auto_reload mid-count takes effect at the next expiry only.
- reset_n asserted mid-count aborts immediately to reset values; reload_reg is lost.

Decomposition:
- Shared package holds the state encoding (IDLE=1'b0, RUN=1'b1) and a WIDTH default constant.
- No sub-module. The FSM, datapath and tc register live in one module; a separate terminal-count comparator is not warranted.

Test Plan:
- Reset mid-run: load 5, start, assert reset_n=0 after 2 cycles -> dout=0, busy=0, tc=0 immediately (asynchronously).
- One-shot: load 4, auto_reload=0, start -> dout 4,3,2,1,0; tc=1 only in the cycle dout=0; busy falls the same cycle; dout stays 0.
- Auto-reload: load 3, auto_reload=1, start -> dout 3,2,1,3,2,1,...; tc=1 on each 1->3 transition, every 3 cycles; busy stays 1.
- Pause and resume: load 10, start, stop when dout=7 -> dout holds 7 with busy=0 for 5 cycles; start -> resumes 6,5,...; tc fires 7 cycles after the resume.
- Priority and corners:
  - load 6 with simultaneous start -> dout=6 and IDLE.
  - start with dout=0 -> ignored.
  - stop+start together in RUN -> pauses.
  - load during RUN -> dout=load_val, IDLE, no tc.
- Width corner with WIDTH=2: load 3, auto_reload=1 -> dout 3,2,1,3 with tc every 3 cycles; no underflow to 3 from 0 in one-shot.
